// File: rtl/outer_ebi_resp.sv
// Off-chip EBI responder: deserialises host request frames from the shared lanes, issues one
// cache-line memory transaction, then serialises the read response or write ack back out.
module outer_ebi_resp #(
    parameter int         DATA_WIDTH       = 64,
    parameter int         PADDR_WIDTH      = 32,
    parameter int         CACHELINE_LENGTH = 512,
    parameter int         EBI_WIDTH        = 16,
    parameter logic [1:0] GRANT_MESI       = 2'b10
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [EBI_WIDTH-1:0]        ebi_i,
    output logic [EBI_WIDTH-1:0]        ebi_o,
    output logic [EBI_WIDTH-1:0]        ebi_oen,
    output logic                        mem_req_valid_o,
    input  logic                        mem_req_ready_i,
    output logic                        mem_req_we_o,
    output logic [PADDR_WIDTH-1:0]      mem_req_addr_o,
    output logic [CACHELINE_LENGTH-1:0] mem_req_wdata_o,
    input  logic                        mem_resp_valid_i,
    output logic                        mem_resp_ready_o,
    input  logic [CACHELINE_LENGTH-1:0] mem_resp_rdata_i,
    output logic                        busy_o,
    output logic                        proto_err_o
);

    localparam int AB  = PADDR_WIDTH / EBI_WIDTH;
    localparam int LB  = CACHELINE_LENGTH / EBI_WIDTH;
    localparam int LBW = (LB > 1) ? $clog2(LB) : 1;

    localparam logic [3:0] OP_DR      = 4'd0;
    localparam logic [3:0] OP_DW1     = 4'd1;
    localparam logic [3:0] OP_DW2     = 4'd2;
    localparam logic [3:0] OP_RD_RESP = 4'd7;
    localparam logic [3:0] OP_ACK     = 4'd15;

    localparam logic [5:0] AB_LAST     = 6'(AB - 1);
    localparam logic [5:0] LB_LAST     = 6'(LB - 1);
    localparam logic [5:0] RD_MESI_IDX = 6'(LB + 2);
    localparam logic [5:0] RD_ID_IDX   = 6'(LB + 3);
    localparam logic [5:0] ACK_LAST    = 6'd1;

    localparam logic [EBI_WIDTH-1:0] ALL_ONES  = {EBI_WIDTH{1'b1}};
    localparam logic [EBI_WIDTH-1:0] ALL_ZEROS = {EBI_WIDTH{1'b0}};

    if (((PADDR_WIDTH % EBI_WIDTH) != 0) || ((CACHELINE_LENGTH % EBI_WIDTH) != 0) ||
        ((CACHELINE_LENGTH % DATA_WIDTH) != 0) || ((LB + 4) > 63)) begin : g_param_check
        $error("outer_ebi_resp: unsupported width combination");
    end

    typedef enum logic [3:0] {
        IDLE, RX_OP, RX_ADDR, RX_ATTR, RX_ID, RX_DATA, MEM_REQ, MEM_WAIT, TURN, TX
    } state_t;

    state_t                      state_r, state_s;
    logic [3:0]                  op_r;
    logic [1:0]                  id_r;
    logic [5:0]                  cnt_r;
    logic [PADDR_WIDTH-1:0]      addr_r;
    logic [CACHELINE_LENGTH-1:0] wdata_r, rdata_r;
    logic [EBI_WIDTH-1:0]        ebi_r, oen_r;
    logic                        req_valid_r, req_we_r, resp_ready_r, busy_r, proto_err_r;
    logic                        proto_err_s, opcode_ok_s;
    logic [5:0]                  tx_idx_s, tx_last_s, data_idx_s;
    logic [EBI_WIDTH-1:0]        tx_beat_s;
    logic [EBI_WIDTH-1:0]        rbeats_s [LB];

    // Next-state logic and the protocol-error strobe
    always_comb begin
        state_s     = state_r;
        proto_err_s = 1'b0;
        opcode_ok_s = (ebi_i[EBI_WIDTH-1:4] == {(EBI_WIDTH-4){1'b0}}) && (ebi_i[3:0] <= OP_DW2);
        tx_last_s   = (op_r == OP_DR) ? RD_ID_IDX : ACK_LAST;
        case (state_r)
            IDLE:     if (ebi_i == ALL_ZEROS) state_s = RX_OP; else state_s = IDLE;
            RX_OP: begin
                if (opcode_ok_s) begin
                    state_s = RX_ADDR;
                end else begin
                    state_s     = IDLE;
                    proto_err_s = 1'b1;
                end
            end
            RX_ADDR:  if (cnt_r == AB_LAST) state_s = RX_ATTR; else state_s = RX_ADDR;
            RX_ATTR: begin
                case (op_r)
                    OP_DR:   state_s = RX_ID;
                    OP_DW1:  state_s = RX_DATA;
                    default: state_s = TURN;
                endcase
            end
            RX_ID:    state_s = MEM_REQ;
            RX_DATA:  if (cnt_r == LB_LAST) state_s = MEM_REQ; else state_s = RX_DATA;
            MEM_REQ:  if (req_valid_r && mem_req_ready_i) state_s = MEM_WAIT; else state_s = MEM_REQ;
            MEM_WAIT: if (mem_resp_valid_i) state_s = TURN; else state_s = MEM_WAIT;
            TURN:     state_s = TX;
            TX:       if (cnt_r == tx_last_s) state_s = IDLE; else state_s = TX;
            default:  state_s = IDLE;
        endcase
    end

    // Transmit beat selection: the beat that will be on the lanes after the coming edge
    always_comb begin
        for (int k = 0; k < LB; k++) begin
            rbeats_s[k] = rdata_r[k*EBI_WIDTH +: EBI_WIDTH];
        end
        if (state_r == TX) begin
            tx_idx_s = cnt_r + 6'd1;
        end else begin
            tx_idx_s = 6'd0;
        end
        data_idx_s = tx_idx_s - 6'd2;
        case (tx_idx_s)
            6'd0:        tx_beat_s = ALL_ZEROS;
            6'd1:        tx_beat_s = {{(EBI_WIDTH-4){1'b0}}, ((op_r == OP_DR) ? OP_RD_RESP : OP_ACK)};
            RD_MESI_IDX: tx_beat_s = {{(EBI_WIDTH-2){1'b0}}, GRANT_MESI};
            RD_ID_IDX:   tx_beat_s = {{(EBI_WIDTH-2){1'b0}}, id_r};
            default:     tx_beat_s = rbeats_s[data_idx_s[LBW-1:0]];
        endcase
    end

    // State, counters, frame capture and registered outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            cnt_r        <= 6'd0;
            op_r         <= 4'd0;
            id_r         <= 2'd0;
            addr_r       <= {PADDR_WIDTH{1'b0}};
            wdata_r      <= {CACHELINE_LENGTH{1'b0}};
            rdata_r      <= {CACHELINE_LENGTH{1'b0}};
            ebi_r        <= ALL_ONES;
            oen_r        <= ALL_ONES;
            req_valid_r  <= 1'b0;
            req_we_r     <= 1'b0;
            resp_ready_r <= 1'b0;
            busy_r       <= 1'b0;
            proto_err_r  <= 1'b0;
        end else begin
            state_r      <= state_s;
            cnt_r        <= (state_s != state_r) ? 6'd0 : cnt_r + 6'd1;
            proto_err_r  <= proto_err_s;
            req_valid_r  <= (state_s == MEM_REQ);
            req_we_r     <= (state_s == MEM_REQ) && (op_r == OP_DW1);
            resp_ready_r <= (state_s == MEM_WAIT);
            busy_r       <= (state_s != IDLE);
            if (state_r == RX_OP) op_r <= ebi_i[3:0];
            if (state_r == RX_ID) id_r <= ebi_i[1:0];
            for (int k = 0; k < AB; k++) begin
                if ((state_r == RX_ADDR) && (cnt_r == 6'(k))) addr_r[k*EBI_WIDTH +: EBI_WIDTH] <= ebi_i;
            end
            for (int k = 0; k < LB; k++) begin
                if ((state_r == RX_DATA) && (cnt_r == 6'(k))) wdata_r[k*EBI_WIDTH +: EBI_WIDTH] <= ebi_i;
            end
            if ((state_r == MEM_WAIT) && mem_resp_valid_i && (op_r == OP_DR)) rdata_r <= mem_resp_rdata_i;
            // Lanes are only driven while in TX; the edge leaving TX releases them together with the data
            if (state_s == TX) begin
                ebi_r <= tx_beat_s;
                oen_r <= ALL_ZEROS;
            end else begin
                ebi_r <= ALL_ONES;
                oen_r <= ALL_ONES;
            end
        end
    end

    assign ebi_o            = ebi_r;
    assign ebi_oen          = oen_r;
    assign mem_req_valid_o  = req_valid_r;
    assign mem_req_we_o     = req_we_r;
    assign mem_req_addr_o   = addr_r;
    assign mem_req_wdata_o  = wdata_r;
    assign mem_resp_ready_o = resp_ready_r;
    assign busy_o           = busy_r;
    assign proto_err_o      = proto_err_r;

endmodule

// File: tb/tb_outer_ebi_resp.sv
// Bench for outer_ebi_resp: a host frame driver, a memory responder and a bus monitor,
// with expected frames and memory requests built from the frame format rules.
module tb_outer_ebi_resp;

    localparam int EW = 16;
    localparam int PW = 32;
    localparam int CL = 512;
    localparam int LB = CL / EW;

    typedef logic [EW-1:0] beat_t;

    logic clk = 1'b0;
    logic rst;
    logic [EW-1:0] ebi_i, ebi_o, ebi_oen;
    logic mem_req_valid_o, mem_req_ready_i, mem_req_we_o;
    logic [PW-1:0] mem_req_addr_o;
    logic [CL-1:0] mem_req_wdata_o, mem_resp_rdata_i;
    logic mem_resp_valid_i, mem_resp_ready_o, busy_o, proto_err_o;

    always #5 clk = ~clk;

    outer_ebi_resp dut (
        .clk(clk), .rst(rst), .ebi_i(ebi_i), .ebi_o(ebi_o), .ebi_oen(ebi_oen),
        .mem_req_valid_o(mem_req_valid_o), .mem_req_ready_i(mem_req_ready_i),
        .mem_req_we_o(mem_req_we_o), .mem_req_addr_o(mem_req_addr_o),
        .mem_req_wdata_o(mem_req_wdata_o), .mem_resp_valid_i(mem_resp_valid_i),
        .mem_resp_ready_o(mem_resp_ready_o), .mem_resp_rdata_i(mem_resp_rdata_i),
        .busy_o(busy_o), .proto_err_o(proto_err_o)
    );

    int checks = 0;
    int failures = 0;

    beat_t   req_q[$];
    beat_t   exp_q[$];
    beat_t   tx_q[$];
    longint  tx_t_q[$];
    int      epoch = 0, seen_epoch = 0;
    int      hs_cnt, valid_cyc, addr_unstable, perr_cyc, oen_low_cyc;
    logic [PW-1:0] hs_addr, prev_addr;
    logic          hs_we, prev_valid;
    logic [CL-1:0] hs_wdata;
    int      ready_delay = 0, resp_wait = 0;
    logic [CL-1:0] resp_line = '0;
    longint  resp_t = 0, last_beat_t = 0;

    // Bus monitor: records transmitted beats and memory-side activity per transaction epoch
    always @(negedge clk) begin
        if (epoch != seen_epoch) begin
            tx_q.delete(); tx_t_q.delete();
            hs_cnt = 0; valid_cyc = 0; addr_unstable = 0; perr_cyc = 0; oen_low_cyc = 0;
            prev_valid = 1'b0; seen_epoch = epoch;
        end
        if (ebi_oen === 16'h0000) begin tx_q.push_back(ebi_o); tx_t_q.push_back($time); end
        if (ebi_oen !== 16'hFFFF) oen_low_cyc++;
        if (mem_req_valid_o === 1'b1 && mem_req_ready_i === 1'b1) begin
            hs_cnt++; hs_addr = mem_req_addr_o; hs_we = mem_req_we_o; hs_wdata = mem_req_wdata_o;
        end
        if (mem_req_valid_o === 1'b1) begin
            valid_cyc++;
            if (prev_valid && mem_req_addr_o !== prev_addr) addr_unstable++;
        end
        prev_valid = (mem_req_valid_o === 1'b1);
        prev_addr  = mem_req_addr_o;
        if (proto_err_o === 1'b1) perr_cyc++;
    end

    // Memory responder: holds ready low for ready_delay cycles, answers resp_wait cycles after the handshake
    initial begin
        mem_req_ready_i = 1'b0; mem_resp_valid_i = 1'b0; mem_resp_rdata_i = '0;
        forever begin
            @(posedge clk); #1;
            if (mem_req_valid_o === 1'b1) begin
                repeat (ready_delay) begin @(posedge clk); #1; end
                mem_req_ready_i = 1'b1;
                @(posedge clk); #1;
                mem_req_ready_i = 1'b0;
                repeat (resp_wait) begin @(posedge clk); #1; end
                mem_resp_valid_i = 1'b1; mem_resp_rdata_i = resp_line; resp_t = $time;
                @(posedge clk); #1;
                mem_resp_valid_i = 1'b0;
            end
        end
    end

    task automatic build_req(input int op, input logic [31:0] addr, input logic [3:0] attr,
                             input logic [1:0] id, input logic [CL-1:0] line);
        beat_t b;
        req_q.delete();
        req_q.push_back(16'h0000);
        b = 16'(op);          req_q.push_back(b);
        req_q.push_back(addr[15:0]);
        req_q.push_back(addr[31:16]);
        b = {12'h000, attr};  req_q.push_back(b);
        if (op == 0) begin b = {14'h0000, id}; req_q.push_back(b); end
        if (op == 1) for (int k = 0; k < LB; k++) req_q.push_back(line[k*EW +: EW]);
    endtask

    task automatic build_resp(input int op, input logic [1:0] id, input logic [CL-1:0] line);
        beat_t b;
        exp_q.delete();
        exp_q.push_back(16'h0000);
        if (op == 0) begin
            exp_q.push_back(16'h0007);
            for (int k = 0; k < LB; k++) exp_q.push_back(line[k*EW +: EW]);
            exp_q.push_back(16'h0002);
            b = {14'h0000, id}; exp_q.push_back(b);
        end else begin
            exp_q.push_back(16'h000F);
        end
    endtask

    task automatic drive_req(input int n);
        for (int i = 0; i < n && i < req_q.size(); i++) begin
            ebi_i = req_q[i]; last_beat_t = $time;
            @(posedge clk); #1;
        end
        ebi_i = 16'hFFFF;
    endtask

    task automatic wait_idle(input int min_beats, output bit timed_out);
        timed_out = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (busy_o === 1'b0 && tx_q.size() >= min_beats) begin timed_out = 1'b0; break; end
            @(posedge clk); #1;
        end
    endtask

    task automatic do_txn(input int op, input logic [31:0] addr, input logic [3:0] attr, input logic [1:0] id,
                          input logic [CL-1:0] wline, input logic [CL-1:0] rline, input int rdy, input int rw,
                          output bit timed_out);
        epoch++;
        ready_delay = rdy; resp_wait = rw; resp_line = rline;
        build_req(op, addr, attr, id, wline);
        build_resp(op, id, rline);
        drive_req(req_q.size());
        wait_idle(exp_q.size(), timed_out);
        @(posedge clk); #1;
    endtask

    function automatic int frame_diff();
        int d = (tx_q.size() > exp_q.size()) ? tx_q.size() - exp_q.size() : exp_q.size() - tx_q.size();
        for (int i = 0; i < tx_q.size() && i < exp_q.size(); i++) if (tx_q[i] !== exp_q[i]) d++;
        return d;
    endfunction

    function automatic logic [CL-1:0] rand_line();
        logic [CL-1:0] l;
        for (int w = 0; w < CL / 32; w++) l[w*32 +: 32] = $urandom;
        return l;
    endfunction

    task automatic test_reset();
        rst = 1'b1; ebi_i = 16'hFFFF;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (ebi_o !== 16'hFFFF) begin failures++; $display("FAIL reset_ebi_o act=%h exp=ffff", ebi_o); end
        checks++; if (ebi_oen !== 16'hFFFF) begin failures++; $display("FAIL reset_oen act=%h exp=ffff", ebi_oen); end
        checks++; if ({mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o} !== 4'b0000) begin
            failures++; $display("FAIL reset_ctrl act=%b exp=0000", {mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o}); end
        rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_dr_read();
        logic [CL-1:0] line; bit to;
        for (int k = 0; k < LB; k++) line[k*EW +: EW] = 16'(k);
        do_txn(0, 32'h8000_1040, 4'h1, 2'd2, '0, line, 0, 3, to);
        checks++; if (to) begin failures++; $display("FAIL dr_timeout beats=%0d exp=%0d", tx_q.size(), exp_q.size()); end
        checks++; if (hs_cnt !== 1 || hs_we !== 1'b0 || hs_addr !== 32'h8000_1040) begin
            failures++; $display("FAIL dr_memreq hs=%0d we=%b addr=%h exp 1/0/80001040", hs_cnt, hs_we, hs_addr); end
        checks++; if (frame_diff() !== 0) begin failures++; $display("FAIL dr_frame diffs=%0d len=%0d exp_len=36", frame_diff(), tx_q.size()); end
        if (tx_t_q.size() > 0) begin
            checks++; if ((tx_t_q[0] - 4 - resp_t) / 10 !== 2) begin
                failures++; $display("FAIL dr_turn act=%0d exp=2 cycles", (tx_t_q[0] - 4 - resp_t) / 10); end
        end
    endtask

    task automatic test_dw1_write();
        logic [CL-1:0] line; bit to;
        for (int k = 0; k < LB; k++) line[k*EW +: EW] = 16'hA000 + 16'(k);
        do_txn(1, 32'h0000_2000, 4'h3, 2'd0, line, '0, 0, 0, to);
        checks++; if (to) begin failures++; $display("FAIL dw1_timeout beats=%0d exp=2", tx_q.size()); end
        checks++; if (hs_cnt !== 1 || hs_we !== 1'b1 || hs_addr !== 32'h0000_2000) begin
            failures++; $display("FAIL dw1_memreq hs=%0d we=%b addr=%h exp 1/1/00002000", hs_cnt, hs_we, hs_addr); end
        checks++; if (hs_wdata[15:0] !== 16'hA000 || hs_wdata[511:496] !== 16'hA01F) begin
            failures++; $display("FAIL dw1_wdata_ends lo=%h hi=%h exp a000/a01f", hs_wdata[15:0], hs_wdata[511:496]); end
        checks++; if (hs_wdata !== line) begin failures++; $display("FAIL dw1_wdata act=%h exp=%h", hs_wdata[63:0], line[63:0]); end
        checks++; if (frame_diff() !== 0) begin failures++; $display("FAIL dw1_ack diffs=%0d", frame_diff()); end
        checks++; if (ebi_o !== 16'hFFFF || ebi_oen !== 16'hFFFF) begin
            failures++; $display("FAIL dw1_bus_release ebi=%h oen=%h exp ffff/ffff", ebi_o, ebi_oen); end
    endtask

    task automatic test_dw2_ack();
        bit to;
        do_txn(2, 32'h0000_3000, 4'h1, 2'd0, '0, '0, 0, 0, to);
        checks++; if (to) begin failures++; $display("FAIL dw2_timeout beats=%0d exp=2", tx_q.size()); end
        checks++; if (valid_cyc !== 0 || hs_cnt !== 0) begin failures++; $display("FAIL dw2_no_mem valid=%0d hs=%0d exp 0/0", valid_cyc, hs_cnt); end
        checks++; if (frame_diff() !== 0) begin failures++; $display("FAIL dw2_ack diffs=%0d", frame_diff()); end
        if (tx_t_q.size() > 0) begin
            checks++; if ((tx_t_q[0] - 4 - last_beat_t) / 10 !== 2) begin
                failures++; $display("FAIL dw2_latency act=%0d exp=2 cycles", (tx_t_q[0] - 4 - last_beat_t) / 10); end
        end
    endtask

    task automatic test_backpressure();
        logic [CL-1:0] line = rand_line(); logic [31:0] addr = $urandom; bit to;
        do_txn(0, addr, 4'h0, 2'd1, '0, line, 10, 1, to);
        checks++; if (to) begin failures++; $display("FAIL bp_timeout beats=%0d", tx_q.size()); end
        checks++; if (valid_cyc !== 11 || addr_unstable !== 0) begin
            failures++; $display("FAIL bp_valid_hold cycles=%0d unstable=%0d exp 11/0", valid_cyc, addr_unstable); end
        checks++; if (hs_cnt !== 1 || hs_addr !== addr) begin failures++; $display("FAIL bp_handshake hs=%0d addr=%h exp 1/%h", hs_cnt, hs_addr, addr); end
        checks++; if (frame_diff() !== 0) begin failures++; $display("FAIL bp_frame diffs=%0d", frame_diff()); end
    endtask

    task automatic test_proto_err();
        logic [CL-1:0] line = rand_line(); bit to;
        epoch++;
        req_q.delete(); req_q.push_back(16'h0000); req_q.push_back(16'h0005);
        drive_req(2);
        repeat (6) begin @(posedge clk); #1; end
        checks++; if (perr_cyc !== 1) begin failures++; $display("FAIL perr_pulse cycles=%0d exp=1", perr_cyc); end
        checks++; if (oen_low_cyc !== 0 || busy_o !== 1'b0 || valid_cyc !== 0) begin
            failures++; $display("FAIL perr_idle oen_low=%0d busy=%b valid=%0d exp 0/0/0", oen_low_cyc, busy_o, valid_cyc); end
        do_txn(0, 32'h1234_5680, 4'h2, 2'd3, '0, line, 0, 0, to);
        checks++; if (to || frame_diff() !== 0 || hs_cnt !== 1) begin
            failures++; $display("FAIL perr_recover to=%0d diffs=%0d hs=%0d exp 0/0/1", to, frame_diff(), hs_cnt); end
    endtask

    task automatic test_reset_mid_frame();
        int n = 0; bit to;
        epoch++;
        build_req(1, 32'h0000_4000, 4'h1, 2'd0, rand_line());
        drive_req(15);
        ebi_i = req_q[15]; rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ebi_o, ebi_oen, mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o} !== {16'hFFFF, 16'hFFFF, 4'b0000}) begin
            failures++; $display("FAIL rst_rxdata ebi=%h oen=%h ctrl=%b exp ffff/ffff/0000", ebi_o, ebi_oen,
                                 {mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o}); end
        rst = 1'b0; ebi_i = 16'hFFFF;
        repeat (3) begin @(posedge clk); #1; end
        checks++; if (valid_cyc !== 0) begin failures++; $display("FAIL rst_rxdata_req valid=%0d exp=0", valid_cyc); end
        epoch++; ready_delay = 0; resp_wait = 0; resp_line = rand_line();
        build_req(0, 32'h0000_5000, 4'h0, 2'd1, '0);
        drive_req(req_q.size());
        for (int c = 0; c < 100; c++) begin
            if (ebi_oen === 16'h0000) n++;
            if (n == 6) break;
            @(posedge clk); #1;
        end
        checks++; if (n != 6) begin failures++; $display("FAIL rst_tx_reach beats=%0d exp=6", n); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++; if ({ebi_o, ebi_oen, mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o} !== {16'hFFFF, 16'hFFFF, 4'b0000}) begin
            failures++; $display("FAIL rst_tx ebi=%h oen=%h ctrl=%b exp ffff/ffff/0000", ebi_o, ebi_oen,
                                 {mem_req_valid_o, mem_resp_ready_o, busy_o, proto_err_o}); end
        rst = 1'b0;
        @(posedge clk); #1;
        do_txn(2, 32'h0000_6000, 4'h2, 2'd0, '0, '0, 0, 0, to);
        checks++; if (to || frame_diff() !== 0 || hs_cnt !== 0) begin
            failures++; $display("FAIL rst_fresh_dw2 to=%0d diffs=%0d hs=%0d exp 0/0/0", to, frame_diff(), hs_cnt); end
    endtask

    task automatic test_random();
        for (int t = 0; t < 12; t++) begin
            int op = $urandom_range(0, 2);
            logic [31:0] addr = $urandom;
            logic [3:0] attr = 4'($urandom);
            logic [1:0] id = 2'($urandom);
            logic [CL-1:0] wl = rand_line();
            logic [CL-1:0] rl = rand_line();
            bit to;
            do_txn(op, addr, attr, id, wl, rl, $urandom_range(0, 4), $urandom_range(0, 4), to);
            checks++; if (to || frame_diff() !== 0) begin
                failures++; $display("FAIL rand_frame t=%0d op=%0d to=%0d diffs=%0d", t, op, to, frame_diff()); end
            if (op == 2) begin
                checks++; if (hs_cnt !== 0) begin failures++; $display("FAIL rand_dw2_mem t=%0d hs=%0d exp=0", t, hs_cnt); end
            end else begin
                checks++; if (hs_cnt !== 1 || hs_addr !== addr || hs_we !== (op == 1)) begin
                    failures++; $display("FAIL rand_memreq t=%0d hs=%0d addr=%h we=%b exp 1/%h/%b", t, hs_cnt, hs_addr, hs_we, addr, op == 1); end
                if (op == 1) begin
                    checks++; if (hs_wdata !== wl) begin failures++; $display("FAIL rand_wdata t=%0d act=%h exp=%h", t, hs_wdata[63:0], wl[63:0]); end
                end
            end
        end
    endtask

    initial begin
        rst = 1'b1; ebi_i = 16'hFFFF;
        test_reset();
        test_dr_read();
        test_dw1_write();
        test_dw2_ack();
        test_backpressure();
        test_proto_err();
        test_reset_mid_frame();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
